// File: rtl/rocketcpu_uart_pkg.sv
`default_nettype none
// ============================================================================
// rocketcpu_uart_pkg
// Shared constants and types for the UART transmit buffer.
// Rev 1.0
// ============================================================================
package rocketcpu_uart_pkg;

  localparam logic ADR_DATA   = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_REQ  = 2'd1,
    DRAIN_GAP  = 2'd2
  } drain_state_e;

  function automatic logic [31:0] pack_status(input logic       empty,
                                              input logic       full,
                                              input logic       ovf,
                                              input logic [7:0] cnt);
    logic [31:0] word;
    word                   = '0;
    word[ST_EMPTY]         = empty;
    word[ST_FULL]          = full;
    word[ST_OVF]           = ovf;
    word[ST_CNT_LSB +: 8]  = cnt;
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rocketcpu_uart_txfifo_fifo.sv
`default_nettype none
// ============================================================================
// rocketcpu_fifo_sync
// Register-array synchronous FIFO with occupancy count and look-ahead count.
// Rev 1.0
// ============================================================================
module rocketcpu_fifo_sync #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   count_nxt
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: dout is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout      = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign count_nxt = count_d;

endmodule
`default_nettype wire

// File: rtl/rocketcpu_uart_txfifo.sv
`default_nettype none
// ============================================================================
// rocketcpu_uart_txfifo
// Wishbone-fed transmit FIFO with a drain master toward the UART data port.
// Rev 1.0
// ============================================================================
module rocketcpu_uart_txfifo
  import rocketcpu_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        i_wb_clk,
  input  logic        reset_n,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [31:0] o_uart_dat,
  output logic [3:0]  o_uart_sel,
  output logic        o_uart_we,
  output logic        o_uart_cyc,
  input  logic        i_uart_ack,
  output logic        o_tx_empty
);

  logic                wb_ack_q,   wb_ack_d;
  logic [31:0]         wb_rdt_q,   wb_rdt_d;
  logic                ovf_q,      ovf_d;
  drain_state_e        state_q,    state_d;
  logic                uart_cyc_q, uart_cyc_d;
  logic [7:0]          uart_byte_q, uart_byte_d;
  logic                tx_empty_q, tx_empty_d;

  logic                fire, data_wr, status_clr, push, pop;
  logic [7:0]          fifo_head;
  logic                fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count, fifo_count_nxt;
  logic [31:0]         status_word;
  logic                unused_ok;

  assign fire       = i_wb_cyc && !wb_ack_q;
  assign data_wr    = fire && i_wb_we && (i_wb_adr == ADR_DATA) && i_wb_sel[0];
  assign status_clr = fire && i_wb_we && (i_wb_adr == ADR_STATUS) && i_wb_dat[ST_OVF];
  // Full is sampled before any same-cycle pop, so a write while full is dropped.
  assign push       = data_wr && !fifo_full;
  assign pop        = (state_q == DRAIN_REQ) && i_uart_ack;

  rocketcpu_fifo_sync #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (i_wb_clk),
    .rst_n     (reset_n),
    .push      (push),
    .din       (i_wb_dat[7:0]),
    .pop       (pop),
    .dout      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt)
  );

  assign status_word = pack_status(fifo_empty, fifo_full, ovf_q, 8'(fifo_count));

  always_comb begin
    wb_ack_d = i_wb_cyc && !wb_ack_q;
    wb_rdt_d = wb_rdt_q;
    if (fire) begin
      wb_rdt_d = (!i_wb_we && (i_wb_adr == ADR_STATUS)) ? status_word : 32'd0;
    end
    ovf_d = ovf_q;
    if (status_clr) begin
      ovf_d = 1'b0;
    end else if (data_wr && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    uart_cyc_d  = uart_cyc_q;
    uart_byte_d = uart_byte_q;
    case (state_q)
      DRAIN_IDLE: begin
        if (!fifo_empty) begin
          uart_byte_d = fifo_head;
          uart_cyc_d  = 1'b1;
          state_d     = DRAIN_REQ;
        end
      end
      DRAIN_REQ: begin
        if (i_uart_ack) begin
          uart_cyc_d = 1'b0;
          state_d    = DRAIN_GAP;
        end
      end
      // The UART's registered ack may still be high here; ignore it.
      DRAIN_GAP: begin
        state_d = DRAIN_IDLE;
      end
      default: begin
        uart_cyc_d = 1'b0;
        state_d    = DRAIN_IDLE;
      end
    endcase
    tx_empty_d = (fifo_count_nxt == '0) && (state_d == DRAIN_IDLE);
  end

  always_ff @(posedge i_wb_clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_q    <= 1'b0;
      wb_rdt_q    <= 32'd0;
      ovf_q       <= 1'b0;
      state_q     <= DRAIN_IDLE;
      uart_cyc_q  <= 1'b0;
      uart_byte_q <= 8'd0;
      tx_empty_q  <= 1'b1;
    end else begin
      wb_ack_q    <= wb_ack_d;
      wb_rdt_q    <= wb_rdt_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      uart_cyc_q  <= uart_cyc_d;
      uart_byte_q <= uart_byte_d;
      tx_empty_q  <= tx_empty_d;
    end
  end

  assign o_wb_ack   = wb_ack_q;
  assign o_wb_rdt   = wb_rdt_q;
  assign o_uart_cyc = uart_cyc_q;
  assign o_uart_we  = uart_cyc_q;
  assign o_uart_sel = {3'b000, uart_cyc_q};
  assign o_uart_dat = {24'd0, uart_byte_q};
  assign o_tx_empty = tx_empty_q;

  assign unused_ok = ^{i_wb_dat[31:8], i_wb_sel[3:1]};

endmodule
`default_nettype wire

// File: tb/tb_rocketcpu_uart_txfifo.sv
`default_nettype none
// ============================================================================
// tb_rocketcpu_uart_txfifo
// Directed bench for the UART transmit FIFO with a programmable UART stub.
// Rev 1.0
// ============================================================================
module tb_rocketcpu_uart_txfifo;

  logic        clk;
  logic        reset_n;
  logic        wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic [31:0] uart_dat;
  logic [3:0]  uart_sel;
  logic        uart_we;
  logic        uart_cyc;
  logic        uart_ack;
  logic        tx_empty;

  int          checks    = 0;
  int          failures  = 0;
  int          stub_mode = 0;   // 0 stall, 1 ack two cycles after cyc, 2 ack held high
  int          stub_cnt  = 0;
  int          proto_bad = 0;
  int          since_hs  = 2;
  logic        prev_cyc  = 1'b0;
  logic [31:0] prev_dat  = 32'd0;
  logic [7:0]  sent_q[$];

  logic [31:0] acc_rdt;
  logic        acc_ack;
  logic        acc_txe;

  typedef struct {
    logic        adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        chk_rdt;
    logic [31:0] exp_rdt;
  } vec_t;

  rocketcpu_uart_txfifo #(.DEPTH_LOG2(4)) dut (
    .i_wb_clk   (clk),
    .reset_n    (reset_n),
    .i_wb_adr   (wb_adr),
    .i_wb_dat   (wb_dat),
    .i_wb_sel   (wb_sel),
    .i_wb_we    (wb_we),
    .i_wb_cyc   (wb_cyc),
    .o_wb_rdt   (wb_rdt),
    .o_wb_ack   (wb_ack),
    .o_uart_dat (uart_dat),
    .o_uart_sel (uart_sel),
    .o_uart_we  (uart_we),
    .o_uart_cyc (uart_cyc),
    .i_uart_ack (uart_ack),
    .o_tx_empty (tx_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // UART stub: ack is updated on the falling edge so it is stable at the rising edge.
  initial begin
    uart_ack = 1'b0;
    forever begin
      @(negedge clk);
      case (stub_mode)
        1: begin
          if (uart_cyc) stub_cnt = stub_cnt + 1;
          else          stub_cnt = 0;
          uart_ack = (stub_cnt >= 2);
        end
        2:       uart_ack = 1'b1;
        default: uart_ack = 1'b0;
      endcase
    end
  end

  // Transfer monitor: logs accepted bytes and flags protocol violations.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        prev_cyc = 1'b0;
        since_hs = 2;
      end else begin
        if (uart_cyc && since_hs < 2) proto_bad = proto_bad + 1;
        if (uart_cyc && (uart_sel != 4'b0001 || uart_dat[31:8] != 24'd0)) proto_bad = proto_bad + 1;
        if (uart_we !== uart_cyc) proto_bad = proto_bad + 1;
        if (uart_cyc && prev_cyc && uart_dat != prev_dat) proto_bad = proto_bad + 1;
        if (uart_cyc && uart_ack) begin
          sent_q.push_back(uart_dat[7:0]);
          since_hs = 0;
        end else if (since_hs < 2) begin
          since_hs = since_hs + 1;
        end
        prev_cyc = uart_cyc;
        prev_dat = uart_dat;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic access(input logic adr, input logic we, input logic [3:0] sel, input logic [31:0] dat);
    @(negedge clk);
    wb_cyc = 1'b1;
    wb_adr = adr;
    wb_we  = we;
    wb_sel = sel;
    wb_dat = dat;
    @(negedge clk);
    acc_ack = wb_ack;
    acc_rdt = wb_rdt;
    acc_txe = tx_empty;
    wb_cyc  = 1'b0;
    wb_we   = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!done) begin
        @(negedge clk);
        if (tx_empty) done = 1'b1;
      end
    end
    chk(name, 32'(tx_empty), 32'd1);
  endtask

  initial begin
    vec_t vecs[11];
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0001};
    vecs[1]  = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 4'h0, 32'h0000_0055, 1'b0, 32'h0000_0000};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0001};
    vecs[4]  = '{1'b0, 1'b1, 4'hE, 32'h0000_0066, 1'b0, 32'h0000_0000};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0001};
    vecs[6]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0004, 1'b0, 32'h0000_0000};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0001};
    vecs[8]  = '{1'b0, 1'b1, 4'hF, 32'h1234_5677, 1'b0, 32'h0000_0000};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0100};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0000};

    reset_n = 1'b0;
    wb_cyc  = 1'b0;
    wb_adr  = 1'b0;
    wb_we   = 1'b0;
    wb_sel  = 4'h0;
    wb_dat  = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx_empty", 32'(tx_empty), 32'd1);
    chk("rst_uart_cyc", 32'(uart_cyc), 32'd0);
    chk("rst_uart_sel", 32'(uart_sel), 32'd0);
    chk("rst_uart_dat", uart_dat, 32'd0);
    chk("rst_wb_ack", 32'(wb_ack), 32'd0);
    chk("rst_wb_rdt", wb_rdt, 32'd0);
    reset_n = 1'b1;

    // Register-level vectors with the UART stalled.
    stub_mode = 0;
    for (int i = 0; i < 11; i++) begin
      access(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].dat);
      chk($sformatf("vec%0d_ack", i), 32'(acc_ack), 32'd1);
      if (vecs[i].chk_rdt) chk($sformatf("vec%0d_rdt", i), acc_rdt, vecs[i].exp_rdt);
    end
    @(negedge clk);
    chk("ack_single_cycle", 32'(wb_ack), 32'd0);
    chk("stalled_req_cyc", 32'(uart_cyc), 32'd1);
    chk("stalled_req_dat", uart_dat, 32'h0000_0077);
    chk("stalled_nothing_sent", 32'(sent_q.size()), 32'd0);
    stub_mode = 1;
    wait_empty("drain_vec_empty", 40);
    chk("drain_vec_count", 32'(sent_q.size()), 32'd1);
    chk("drain_vec_byte", 32'(sent_q[0]), 32'h77);
    sent_q.delete();

    // Single byte with a two-cycle UART latency.
    access(1'b0, 1'b1, 4'h1, 32'h0000_0041);
    chk("t2_tx_empty_drops", 32'(acc_txe), 32'd0);
    wait_empty("t2_empty", 40);
    chk("t2_count", 32'(sent_q.size()), 32'd1);
    chk("t2_byte", 32'(sent_q[0]), 32'h41);
    chk("t2_proto", 32'(proto_bad), 32'd0);
    sent_q.delete();

    // Fill to full, overflow, sticky-bit handling.
    stub_mode = 0;
    for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 4'h1, 32'h10 + i);
    access(1'b1, 1'b0, 4'h0, 32'd0);
    chk("t3_status_full", acc_rdt, 32'h0000_1002);
    access(1'b0, 1'b1, 4'h1, 32'h0000_0020);
    chk("t3_ovf_ack", 32'(acc_ack), 32'd1);
    access(1'b1, 1'b0, 4'h0, 32'd0);
    chk("t3_status_ovf", acc_rdt, 32'h0000_1006);
    access(1'b1, 1'b1, 4'hF, 32'h0000_0003);
    access(1'b1, 1'b0, 4'h0, 32'd0);
    chk("t3_ovf_sticky", acc_rdt, 32'h0000_1006);
    access(1'b1, 1'b1, 4'hF, 32'h0000_0004);
    access(1'b1, 1'b0, 4'h0, 32'd0);
    chk("t4_ovf_cleared", acc_rdt, 32'h0000_1002);
    chk("t3_stalled_none", 32'(sent_q.size()), 32'd0);
    stub_mode = 1;
    wait_empty("t3_empty", 200);
    chk("t3_count", 32'(sent_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("t3_byte%0d", i), 32'(sent_q[i]), 32'h10 + i);
    access(1'b1, 1'b0, 4'h0, 32'd0);
    chk("t3_status_after", acc_rdt, 32'h0000_0001);
    sent_q.delete();

    // Ack held high: one pop per request, 32 bytes across pointer wrap.
    stub_mode = 2;
    for (int i = 0; i < 32; i++) access(1'b0, 1'b1, 4'h1, 32'h80 + i);
    wait_empty("t5_empty", 300);
    chk("t5_count", 32'(sent_q.size()), 32'd32);
    for (int i = 0; i < 32; i++) chk($sformatf("t5_byte%0d", i), 32'(sent_q[i]), 32'h80 + i);
    access(1'b1, 1'b0, 4'h0, 32'd0);
    chk("t5_status_after", acc_rdt, 32'h0000_0001);
    chk("t5_proto", 32'(proto_bad), 32'd0);
    sent_q.delete();

    // Reset asserted mid-request with bytes queued.
    stub_mode = 0;
    for (int i = 0; i < 5; i++) access(1'b0, 1'b1, 4'h1, 32'hA0 + i);
    @(negedge clk);
    chk("t6_in_req", 32'(uart_cyc), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_cyc_async_drop", 32'(uart_cyc), 32'd0);
    chk("t6_tx_empty_async", 32'(tx_empty), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    access(1'b1, 1'b0, 4'h0, 32'd0);
    chk("t6_status_after", acc_rdt, 32'h0000_0001);
    repeat (4) @(negedge clk);
    chk("t6_cyc_idle", 32'(uart_cyc), 32'd0);
    chk("t6_nothing_sent", 32'(sent_q.size()), 32'd0);
    chk("final_proto", 32'(proto_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rocketcpu_uart_txfifo.md
Name: rocketcpu_uart_txfifo

Overview:
Transmit buffer placed directly upstream of the UART core. CPU Wishbone writes push bytes into a FIFO without stalling. A drain FSM acts as a Wishbone master toward the UART data port and retries until the UART accepts each byte. A status word and an "all sent" interrupt let firmware poll or sleep instead of busy-waiting on the UART's stalled ack.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 bytes); legal range 1..7.

Ports:
i_wb_clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
i_wb_adr  in  1  word select: 0 = DATA, 1 = STATUS.
i_wb_dat  in  32  CPU write data.
i_wb_sel  in  4  byte enables.
i_wb_we  in  1  write strobe.
i_wb_cyc  in  1  cycle valid.
o_wb_rdt  out  32  read data.
o_wb_ack  out  1  single-cycle acknowledge.
o_uart_dat  out  32  byte to the UART, zero-extended.
o_uart_sel  out  4  always 4'b0001 while o_uart_cyc is high.
o_uart_we  out  1  equals o_uart_cyc.
o_uart_cyc  out  1  write request to the UART.
i_uart_ack  in  1  UART accept; the UART holds it low while its shifter is busy.
o_tx_empty  out  1  high when the FIFO is empty and the FSM is in IDLE.

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers 0, overflow 0, FSM IDLE. All outputs 0 except o_tx_empty=1.
- CPU ack: o_wb_ack <= i_wb_cyc && !o_wb_ack. Every access is acked exactly 1 cycle after cyc rises and never stalls. A held cyc produces alternating acks; the master drops cyc on ack.
- An access "fires" on a cycle with i_wb_cyc && !o_wb_ack. Side effects happen only on firing cycles.
- DATA write (adr=0, we, sel[0]):
  - FIFO not full: push i_wb_dat[7:0].
  - FIFO full: drop the byte, set sticky overflow, still ack.
  - sel[0]=0: no push.
- STATUS write (adr=1, we): if i_wb_dat[2]=1, clear overflow. Other bits ignored.
- Reads: o_wb_rdt is registered on the firing cycle and valid with ack.
  - DATA read returns 0.
  - STATUS: bit0 empty, bit1 full, bit2 overflow, bits[15:8] count (zero-extended), all other bits 0.
- FIFO: register array, 2^DEPTH_LOG2 x 8. rd_ptr/wr_ptr are DEPTH_LOG2 bits and wrap naturally. Count is DEPTH_LOG2+1 bits.
  - full = (count == 2^DEPTH_LOG2); empty = (count == 0).
  - Push and pop in the same cycle: both execute, count unchanged.
  - Full is evaluated before a same-cycle pop: a write while full is dropped even if a pop occurs that cycle.
- Drain FSM (states IDLE, REQ, GAP):
  - IDLE: if !empty, latch o_uart_dat={24'b0, head}, set o_uart_cyc=1, go to REQ.
  - REQ: hold cyc and data stable. On i_uart_ack: pop, cyc<=0, go to GAP.
  - GAP: 1 cycle with cyc=0. i_uart_ack is ignored here, because the UART's registered ack can still read high. Then go to IDLE.
  - Minimum spacing is 3 cycles per byte; UART framing dominates the real rate.
- o_tx_empty is registered, derived from next-state empty && next FSM == IDLE. It deasserts the cycle after the first push.
- Reset mid-transfer: cyc drops immediately (async); queued bytes are discarded.
- i_uart_ack in IDLE is ignored.

Decomposition:
- Package rocketcpu_uart_pkg holds:
  - address constants ADR_DATA=0, ADR_STATUS=1;
  - status bit indices ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_CNT_LSB=8;
  - FSM state encoding (2-bit, IDLE/REQ/GAP).
- One sub-module, rocketcpu_fifo_sync: parameterised width/depth, push/pop/full/empty/count, async active-low reset. The top level holds the Wishbone slave, status logic and drain FSM.

Test Plan:
- Reset, then read STATUS -> rdt=0x00000001, o_tx_empty=1, o_uart_cyc=0.
- Write 0x41 to DATA with the UART stub acking 2 cycles after cyc -> o_uart_dat=0x41, sel=0001 for the whole request; cyc drops the cycle after ack; o_tx_empty returns to 1; exactly one byte observed.
- Write 0x10..0x1F (16 bytes) with the UART stub stalled, then write 0x20 -> STATUS=0x00001006 (count 16, full, overflow); after releasing the stub, bytes 0x10..0x1F are seen in order and 0x20 is never sent.
- Write 0x4 to STATUS after the overflow -> overflow bit reads 0, count unaffected.
- Stub holds ack high continuously -> the FSM pops once per REQ, with GAP enforced; no byte is duplicated or skipped across 32 bytes with pointer wrap.
- Assert reset_n low during REQ with 5 bytes queued -> o_uart_cyc falls immediately; STATUS after release = 0x00000001.
